// File: rtl/uart_sort_pkg.sv
// Shared types and sizing helpers for the UART sort datapath.
package uart_sort_pkg;

  // Default datapath geometry.
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned BPW       = DEF_WIDTH / 8;
  localparam int unsigned SEQ_BITS  = DEF_WIDTH * DEF_DEPTH;

  // Assembly FSM encoding.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } asm_state_e;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB-first and strobes a
// completed word on the cycle its last byte arrives.
module byte_word_packer
  import uart_sort_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned NB    = bytes_per_word(WIDTH),
  localparam int unsigned BIW   = idx_width(NB)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIW-1:0]   idx_q, idx_d;
  logic             last_byte;

  // The word including the byte arriving this cycle; first byte ends up in the MSBs.
  assign word_o       = (shift_q << 8) | WIDTH'(byte_i);
  assign last_byte    = (idx_q == BIW'(NB - 1));
  assign word_valid_o = byte_valid_i && !clear_i && last_byte;

  // Next-state: clear discards a partial word, otherwise shift on each byte.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = word_o;
      idx_d   = last_byte ? '0 : idx_q + BIW'(1);
    end
  end

  // Shift register and byte index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/uart_seq_assembler.sv
// Groups received bytes into DEPTH-word sequences and hands them to the
// sorter over valid/ready, tracking handoffs, overflow and inter-byte timeout.
module uart_seq_assembler
  import uart_sort_pkg::*;
#(
  parameter  int unsigned WIDTH          = 32,
  parameter  int unsigned DEPTH          = 8,
  parameter  int unsigned NUM_SEQ        = 10,
  parameter  int unsigned TIMEOUT_CYCLES = 10000000,
  localparam int unsigned SEQ_W          = WIDTH * DEPTH,
  localparam int unsigned WIW            = idx_width(DEPTH),
  localparam int unsigned CNT_W          = $clog2(NUM_SEQ + 1),
  localparam int unsigned TMO_W          = idx_width(TIMEOUT_CYCLES)
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [SEQ_W-1:0] seq_data,
  output logic             seq_valid,
  input  logic             seq_ready,
  output logic [CNT_W-1:0] seq_count,
  output logic             all_done,
  output logic             busy,
  output logic             overflow,
  output logic             timeout_err
);

  asm_state_e       state_q, state_d;
  logic [WIW-1:0]   word_idx_q, word_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SEQ_W-1:0] asm_q, asm_d, asm_full;
  logic [SEQ_W-1:0] seq_data_q, seq_data_d;
  logic             seq_valid_q, seq_valid_d;
  logic [CNT_W-1:0] seq_count_q, seq_count_d;
  logic             overflow_q, overflow_d;
  logic             timeout_err_q, timeout_err_d;

  logic             byte_acc, tmo_expired, last_word, seq_final, handshake, slot_free;
  logic [WIDTH-1:0] word;
  logic             word_valid;

  // Bytes are ignored once all sequences have been handed off.
  assign byte_acc    = rx_valid && (state_q != StDone);
  // An arriving byte beats an expiring counter.
  assign tmo_expired = (state_q == StCollect) && !byte_acc &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign last_word   = (word_idx_q == WIW'(DEPTH - 1));
  assign seq_final   = word_valid && last_word;
  assign handshake   = seq_valid_q && seq_ready;
  assign slot_free   = !seq_valid_q || seq_ready;

  byte_word_packer #(
    .WIDTH (WIDTH)
  ) u_packer (
    .clk_i        (CLK100MHZ),
    .rst_ni       (rst),
    .byte_i       (rx_data),
    .byte_valid_i (byte_acc),
    .clear_i      (tmo_expired),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Assembly image including any word completing this cycle.
  always_comb begin
    asm_full = asm_q;
    if (word_valid) begin
      asm_full[int'(word_idx_q) * WIDTH +: WIDTH] = word;
    end
  end

  // Assembly FSM next state; DONE takes over as soon as the final handoff lands.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (byte_acc) state_d = seq_final ? StIdle : StCollect;
      end
      StCollect: begin
        if (seq_final || tmo_expired) state_d = StIdle;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (seq_count_d == CNT_W'(NUM_SEQ)) state_d = StDone;
  end

  // Datapath next state: word placement, timeout, output slot and counters.
  always_comb begin
    word_idx_d    = word_idx_q;
    tmo_d         = tmo_q;
    asm_d         = asm_full;
    seq_data_d    = seq_data_q;
    seq_valid_d   = seq_valid_q;
    seq_count_d   = seq_count_q;
    overflow_d    = overflow_q;
    timeout_err_d = timeout_err_q;

    if (tmo_expired) begin
      word_idx_d = '0;
    end else if (word_valid) begin
      word_idx_d = last_word ? '0 : word_idx_q + WIW'(1);
    end

    if (byte_acc || state_q != StCollect || tmo_expired) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (tmo_expired) begin
      asm_d         = '0;
      timeout_err_d = 1'b1;
    end

    if (handshake) seq_valid_d = 1'b0;
    if (seq_final) begin
      if (slot_free) begin
        seq_data_d  = asm_full;
        seq_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (handshake && seq_count_q != CNT_W'(NUM_SEQ)) begin
      seq_count_d = seq_count_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      word_idx_q    <= '0;
      tmo_q         <= '0;
      asm_q         <= '0;
      seq_data_q    <= '0;
      seq_valid_q   <= 1'b0;
      seq_count_q   <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      tmo_q         <= tmo_d;
      asm_q         <= asm_d;
      seq_data_q    <= seq_data_d;
      seq_valid_q   <= seq_valid_d;
      seq_count_q   <= seq_count_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign seq_data    = seq_data_q;
  assign seq_valid   = seq_valid_q;
  assign seq_count   = seq_count_q;
  assign all_done    = (seq_count_q == CNT_W'(NUM_SEQ));
  assign busy        = (state_q == StCollect);
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_seq_assembler.sv
// Scoreboard bench for uart_seq_assembler: expected sequences are queued as
// stimulus is issued and a negedge monitor checks every handshake.
module tb_uart_seq_assembler;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned N  = 2;
  localparam int unsigned T  = 100;
  localparam int unsigned SB = W * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          seq_ready = 1'b1;
  logic [SB-1:0] seq_data;
  logic          seq_valid;
  logic [1:0]    seq_count;
  logic          all_done, busy, overflow, timeout_err;

  int checks = 0;
  int failures = 0;
  logic [SB-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_seq_assembler #(
    .WIDTH          (W),
    .DEPTH          (D),
    .NUM_SEQ        (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK100MHZ   (clk),
    .rst         (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .seq_data    (seq_data),
    .seq_valid   (seq_valid),
    .seq_ready   (seq_ready),
    .seq_count   (seq_count),
    .all_done    (all_done),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  // Sequence of 32 consecutive bytes starting at base, big-endian per word.
  function automatic logic [SB-1:0] exp_seq(input logic [7:0] base);
    logic [SB-1:0] v;
    v = '0;
    for (int k = 0; k < int'(D); k++) begin
      for (int j = 0; j < 4; j++) begin
        v[k*32 + (3-j)*8 +: 8] = base + 8'(4*k + j);
      end
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [SB-1:0] act, input logic [SB-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] base, input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      send_byte(base + 8'(i));
      idle(gap);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    idle(2);
    rst_n    = 1'b1;
    idle(1);
  endtask

  // Monitor: a handshake happens at the next posedge whenever valid && ready here.
  always @(negedge clk) begin
    if (rst_n && seq_valid && seq_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_handshake actual=%0h required=none", seq_data);
      end else begin
        check("handshake_data", seq_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state.
    #12;
    check("rst_seq_valid", SB'(seq_valid), SB'(0));
    check("rst_seq_data", seq_data, SB'(0));
    check("rst_busy", SB'(busy), SB'(0));
    check("rst_count", SB'(seq_count), SB'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Basic sequence with idle gaps; 1-cycle output latency.
    exp_q.push_back(exp_seq(8'h00));
    send_bytes(8'h00, 31, 3);
    check("basic_valid_before", SB'(seq_valid), SB'(0));
    check("basic_busy", SB'(busy), SB'(1));
    send_byte(8'h1F);
    check("basic_valid_after", SB'(seq_valid), SB'(1));
    check("basic_word0", SB'(seq_data[31:0]), SB'(32'h00010203));
    check("basic_word7", SB'(seq_data[255:224]), SB'(32'h1C1D1E1F));
    idle(2);
    check("basic_count", SB'(seq_count), SB'(1));
    check("basic_valid_clear", SB'(seq_valid), SB'(0));

    // Backpressure and overflow.
    do_reset();
    seq_ready = 1'b0;
    exp_q.push_back(exp_seq(8'h40));
    send_bytes(8'h40, 32, 0);
    send_bytes(8'h80, 32, 0);
    idle(1);
    check("bp_hold_data", seq_data, exp_seq(8'h40));
    check("bp_overflow", SB'(overflow), SB'(1));
    check("bp_count0", SB'(seq_count), SB'(0));
    seq_ready = 1'b1;
    idle(3);
    check("bp_count1", SB'(seq_count), SB'(1));
    check("bp_valid_clear", SB'(seq_valid), SB'(0));

    // Same-cycle free: slot empties as B completes.
    do_reset();
    seq_ready = 1'b0;
    exp_q.push_back(exp_seq(8'h10));
    exp_q.push_back(exp_seq(8'h30));
    send_bytes(8'h10, 32, 0);
    send_bytes(8'h30, 31, 0);
    check("sc_valid_before", SB'(seq_valid), SB'(1));
    rx_data   = 8'h4F;
    rx_valid  = 1'b1;
    seq_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    seq_ready = 1'b0;
    check("sc_valid_after", SB'(seq_valid), SB'(1));
    check("sc_data_b", seq_data, exp_seq(8'h30));
    check("sc_no_overflow", SB'(overflow), SB'(0));
    check("sc_count1", SB'(seq_count), SB'(1));
    seq_ready = 1'b1;
    idle(2);
    check("sc_count2", SB'(seq_count), SB'(2));
    check("sc_all_done", SB'(all_done), SB'(1));

    // Timeout after 100 idle cycles mid-sequence.
    do_reset();
    send_bytes(8'hA0, 5, 0);
    idle(T - 1);
    check("tmo_not_yet", SB'(timeout_err), SB'(0));
    check("tmo_busy_before", SB'(busy), SB'(1));
    idle(1);
    check("tmo_err", SB'(timeout_err), SB'(1));
    check("tmo_busy", SB'(busy), SB'(0));
    exp_q.push_back(exp_seq(8'h20));
    send_bytes(8'h20, 32, 0);
    idle(2);
    check("tmo_count", SB'(seq_count), SB'(1));
    check("tmo_sticky", SB'(timeout_err), SB'(1));

    // Byte on the expiry cycle beats the timeout.
    do_reset();
    send_bytes(8'hB0, 5, 0);
    idle(T - 1);
    send_byte(8'hB5);
    check("tie_no_err", SB'(timeout_err), SB'(0));
    check("tie_busy", SB'(busy), SB'(1));

    // Done then asynchronous reset mid-stream.
    do_reset();
    exp_q.push_back(exp_seq(8'h00));
    exp_q.push_back(exp_seq(8'h60));
    send_bytes(8'h00, 32, 0);
    send_bytes(8'h60, 32, 0);
    idle(2);
    check("done_all_done", SB'(all_done), SB'(1));
    check("done_count", SB'(seq_count), SB'(2));
    send_bytes(8'hC0, 3, 0);
    check("done_busy", SB'(busy), SB'(0));
    check("done_valid", SB'(seq_valid), SB'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_all_done", SB'(all_done), SB'(0));
    check("async_count", SB'(seq_count), SB'(0));
    check("async_data", seq_data, SB'(0));
    check("async_flags", SB'({overflow, timeout_err, busy, seq_valid}), SB'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send_bytes(8'hD0, 7, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy_mid", SB'(busy), SB'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(exp_seq(8'h70));
    send_bytes(8'h70, 32, 0);
    idle(2);
    check("restart_count", SB'(seq_count), SB'(1));

    check("queue_empty", SB'(exp_q.size()), SB'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
